switch_allocator_rr: RTL

SWITCH_ALLOCATOR_RR -- requirements
Module: switch_allocator_rr

---
 rtl/switch_allocator_rr.sv | 117 +++++++++++
 1 files changed

// File: rtl/switch_allocator_rr.sv
// 5x5 wormhole switch allocator: per-output round-robin arbitration with packet locking.
// Latency: grants are combinational (zero cycle); lock/pointer state updates on the next edge.
// Backpressure: out_ready low holds the output's selection and state until the flit can move.
module switch_allocator_rr (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  in_valid,
    input  logic [14:0] in_dest,
    input  logic [4:0]  in_tail,
    input  logic [4:0]  out_ready,
    output logic [4:0]  in_grant,
    output logic [4:0]  out_valid,
    output logic [14:0] out_sel,
    output logic [4:0]  out_busy
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t     state_q [5];
    state_t     state_d [5];
    logic [2:0] owner_q [5];
    logic [2:0] owner_d [5];
    logic [2:0] ptr_q   [5];
    logic [2:0] ptr_d   [5];

    logic [4:0] req [5];   // req[o][i]: input i wants output o
    logic [2:0] sel [5];
    logic [4:0] vld;
    logic [4:0] xfer;
    logic [3:0] idx;

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                req[o][i] = in_valid[i] && (in_dest[3*i +: 3] == 3'(o));
            end
        end
    end

    // Scan from ptr downward in priority so the first hit after ptr wins last.
    always_comb begin
        idx  = '0;
        vld  = '0;
        xfer = '0;
        for (int o = 0; o < 5; o++) begin
            sel[o] = 3'b111;
            if (state_q[o] == ST_LOCKED) begin
                if (req[o][owner_q[o]]) begin
                    sel[o] = owner_q[o];
                    vld[o] = 1'b1;
                end
            end else begin
                for (int k = 4; k >= 0; k--) begin
                    idx = {1'b0, ptr_q[o]} + 4'(k);
                    if (idx >= 4'd5) idx = idx - 4'd5;
                    if (req[o][idx[2:0]]) begin
                        sel[o] = idx[2:0];
                        vld[o] = 1'b1;
                    end
                end
            end
            if (reset) begin
                sel[o] = 3'b111;
                vld[o] = 1'b0;
            end
            xfer[o] = vld[o] & out_ready[o];
        end
    end

    always_comb begin
        in_grant  = '0;
        out_valid = vld;
        out_sel   = '0;
        out_busy  = '0;
        for (int o = 0; o < 5; o++) begin
            out_sel[3*o +: 3] = sel[o];
            out_busy[o]       = !reset && (state_q[o] == ST_LOCKED);
            for (int i = 0; i < 5; i++) begin
                if (xfer[o] && (sel[o] == 3'(i))) in_grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            if (xfer[o]) begin
                if (state_q[o] == ST_IDLE) begin
                    ptr_d[o] = (sel[o] == 3'd4) ? 3'd0 : sel[o] + 3'd1;
                    if (!in_tail[sel[o]]) begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = sel[o];
                    end
                end else if (in_tail[sel[o]]) begin
                    state_d[o] = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < 5; o++) begin
            if (reset) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= 3'd0;
                ptr_q[o]   <= 3'd0;
            end else begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule
